// File: rtl/fetch_stall_ctrl.sv
// rtl/fetch_stall_ctrl.sv - PC, IF/ID and ID/EX control registers with hazard stall, branch flush and stall watchdog
// Optional feature macro: STALL_PERF_EN (adds Stall_Cnt / Flush_Cnt performance counters).
module fetch_stall_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CTRL_W    = 10,
    parameter int          MAX_STALL = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PCWrite,
    input  logic              IF_ID_Write,
    input  logic              NOP,
    input  logic              Branch_Taken,
    input  logic [31:0]       Branch_Target,
    input  logic [31:0]       Instr_in,
    input  logic [CTRL_W-1:0] ID_Ctrl_in,
    output logic [31:0]       PC,
    output logic [31:0]       IF_ID_Instr,
    output logic [31:0]       IF_ID_PC4,
    output logic              IF_ID_Valid,
    output logic [CTRL_W-1:0] ID_EX_Ctrl,
`ifdef STALL_PERF_EN
    output logic [31:0]       Stall_Cnt,
    output logic [31:0]       Flush_Cnt,
`endif
    output logic              Stall_Err
);

    localparam int CW = $clog2(MAX_STALL + 1);

    logic              stall;
    logic              flush;
    logic [31:0]       pc_plus4;

    logic [31:0]       pc_q, pc_d;
    logic [31:0]       if_id_instr_q, if_id_instr_d;
    logic [31:0]       if_id_pc4_q, if_id_pc4_d;
    logic              if_id_valid_q, if_id_valid_d;
    logic [CTRL_W-1:0] id_ex_ctrl_q, id_ex_ctrl_d;
    logic [CW-1:0]     stall_cnt_q, stall_cnt_d;
    logic              stall_err_q, stall_err_d;

    // A branch resolved while stalled used stale operands, so only an unstalled branch flushes.
    assign stall    = !PCWrite || !IF_ID_Write;
    assign flush    = Branch_Taken && !stall;
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d = pc_q;
        if (!stall) begin
            pc_d = Branch_Taken ? Branch_Target : pc_plus4;
        end

        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;
        if (IF_ID_Write) begin
            if (flush) begin
                if_id_instr_d = 32'd0;
                if_id_pc4_d   = 32'd0;
                if_id_valid_d = 1'b0;
            end else begin
                if_id_instr_d = Instr_in;
                if_id_pc4_d   = pc_plus4;
                if_id_valid_d = 1'b1;
            end
        end

        id_ex_ctrl_d = (NOP || !if_id_valid_q) ? '0 : ID_Ctrl_in;

        stall_cnt_d = '0;
        if (stall) begin
            stall_cnt_d = (stall_cnt_q == CW'(MAX_STALL)) ? stall_cnt_q : stall_cnt_q + CW'(1);
        end
        stall_err_d = stall_err_q || (stall_cnt_d == CW'(MAX_STALL));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            if_id_instr_q <= 32'd0;
            if_id_pc4_q   <= 32'd0;
            if_id_valid_q <= 1'b0;
            id_ex_ctrl_q  <= '0;
            stall_cnt_q   <= '0;
            stall_err_q   <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
            id_ex_ctrl_q  <= id_ex_ctrl_d;
            stall_cnt_q   <= stall_cnt_d;
            stall_err_q   <= stall_err_d;
        end
    end

`ifdef STALL_PERF_EN
    logic [31:0] stall_perf_q;
    logic [31:0] flush_perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_perf_q <= 32'd0;
            flush_perf_q <= 32'd0;
        end else begin
            if (stall) stall_perf_q <= stall_perf_q + 32'd1;
            if (flush) flush_perf_q <= flush_perf_q + 32'd1;
        end
    end

    assign Stall_Cnt = stall_perf_q;
    assign Flush_Cnt = flush_perf_q;
`endif

    assign PC          = pc_q;
    assign IF_ID_Instr = if_id_instr_q;
    assign IF_ID_PC4   = if_id_pc4_q;
    assign IF_ID_Valid = if_id_valid_q;
    assign ID_EX_Ctrl  = id_ex_ctrl_q;
    assign Stall_Err   = stall_err_q;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// tb/tb_fetch_stall_ctrl.sv - directed self-checking bench for fetch_stall_ctrl
module tb_fetch_stall_ctrl;

    localparam logic [9:0] CTRL = 10'h2AB;

    logic        clk;
    logic        rst_n;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        NOP;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic [31:0] Instr_in;
    logic [9:0]  ID_Ctrl_in;
    logic [31:0] PC;
    logic [31:0] IF_ID_Instr;
    logic [31:0] IF_ID_PC4;
    logic        IF_ID_Valid;
    logic [9:0]  ID_EX_Ctrl;
    logic        Stall_Err;
`ifdef STALL_PERF_EN
    logic [31:0] Stall_Cnt;
    logic [31:0] Flush_Cnt;
`endif

    int n_checks;
    int n_fail;

    fetch_stall_ctrl #(.RESET_PC(32'h0), .CTRL_W(10), .MAX_STALL(4)) dut (
        .clk(clk), .rst_n(rst_n), .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .NOP(NOP),
        .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target), .Instr_in(Instr_in),
        .ID_Ctrl_in(ID_Ctrl_in), .PC(PC), .IF_ID_Instr(IF_ID_Instr), .IF_ID_PC4(IF_ID_PC4),
        .IF_ID_Valid(IF_ID_Valid), .ID_EX_Ctrl(ID_EX_Ctrl),
`ifdef STALL_PERF_EN
        .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt),
`endif
        .Stall_Err(Stall_Err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: data is a fixed scramble of the address.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h1357_0000;
    endfunction

    assign Instr_in = mem(PC);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic pcw, input logic ifw, input logic nop,
                          input logic br, input logic [31:0] tgt);
        PCWrite = pcw; IF_ID_Write = ifw; NOP = nop; Branch_Taken = br; Branch_Target = tgt;
    endtask

    task automatic chk_if(input string name, input logic [31:0] pc_e, input logic [31:0] ins_e,
                          input logic [31:0] pc4_e, input logic v_e, input logic [9:0] c_e);
        n_checks++;
        if (PC !== pc_e || IF_ID_Instr !== ins_e || IF_ID_PC4 !== pc4_e ||
            IF_ID_Valid !== v_e || ID_EX_Ctrl !== c_e) begin
            n_fail++;
            $display("FAIL %s actual pc=%h ins=%h pc4=%h v=%b ctrl=%h required pc=%h ins=%h pc4=%h v=%b ctrl=%h",
                     name, PC, IF_ID_Instr, IF_ID_PC4, IF_ID_Valid, ID_EX_Ctrl,
                     pc_e, ins_e, pc4_e, v_e, c_e);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        chk_if("reset_regs", 32'h0, 32'h0, 32'h0, 1'b0, 10'h0);
        n_checks++;
        if (Stall_Err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err actual=%b required=0", Stall_Err);
        end
    endtask

    task automatic test_sequential();
        step(); chk_if("seq_e1", 32'h4, mem(32'h0), 32'h4, 1'b1, 10'h0);
        step(); chk_if("seq_e2", 32'h8, mem(32'h4), 32'h8, 1'b1, CTRL);
    endtask

    task automatic test_load_use();
        set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        step(); chk_if("lu_hold", 32'h8, mem(32'h4), 32'h8, 1'b1, 10'h0);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step(); chk_if("lu_resume", 32'hC, mem(32'h8), 32'hC, 1'b1, CTRL);
        step(); chk_if("lu_pc10", 32'h10, mem(32'hC), 32'h10, 1'b1, CTRL);
    endtask

    task automatic test_branch();
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h40);
        step(); chk_if("br_flush", 32'h40, 32'h0, 32'h0, 1'b0, CTRL);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step(); chk_if("br_bubble", 32'h44, mem(32'h40), 32'h44, 1'b1, 10'h0);
    endtask

    task automatic test_branch_under_stall();
        set_in(1'b0, 1'b0, 1'b1, 1'b1, 32'h80);
        step(); chk_if("bs_ignored", 32'h44, mem(32'h40), 32'h44, 1'b1, 10'h0);
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'h80);
        step(); chk_if("bs_taken", 32'h80, 32'h0, 32'h0, 1'b0, CTRL);
`ifdef STALL_PERF_EN
        n_checks++;
        if (Stall_Cnt !== 32'd2 || Flush_Cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL perf_cnt actual stall=%0d flush=%0d required stall=2 flush=2", Stall_Cnt, Flush_Cnt);
        end
`endif
    endtask

    task automatic test_inconsistent();
        set_in(1'b1, 1'b0, 1'b0, 1'b1, 32'h200);
        step(); chk_if("inc_ifid_hold", 32'h80, 32'h0, 32'h0, 1'b0, 10'h0);
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 32'h200);
        step(); chk_if("inc_pc_hold", 32'h80, mem(32'h80), 32'h84, 1'b1, 10'h0);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step(); chk_if("inc_resume", 32'h84, mem(32'h80), 32'h84, 1'b1, CTRL);
        n_checks++;
        if (Stall_Err !== 1'b0) begin
            n_fail++; $display("FAIL inc_err actual=%b required=0", Stall_Err);
        end
    endtask

    task automatic test_watchdog();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) step();
        n_checks++;
        if (Stall_Err !== 1'b0) begin
            n_fail++; $display("FAIL wd_3 actual=%b required=0", Stall_Err);
        end
        step();
        n_checks++;
        if (Stall_Err !== 1'b1) begin
            n_fail++; $display("FAIL wd_4 actual=%b required=1", Stall_Err);
        end
        chk_if("wd_pc_held", 32'h84, mem(32'h80), 32'h84, 1'b1, CTRL);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        repeat (2) step();
        n_checks++;
        if (Stall_Err !== 1'b1) begin
            n_fail++; $display("FAIL wd_sticky actual=%b required=1", Stall_Err);
        end
        #2 rst_n = 1'b0;
        #1;
        chk_if("wd_async_rst", 32'h0, 32'h0, 32'h0, 1'b0, 10'h0);
        n_checks++;
        if (Stall_Err !== 1'b0) begin
            n_fail++; $display("FAIL wd_rst_err actual=%b required=0", Stall_Err);
        end
`ifdef STALL_PERF_EN
        n_checks++;
        if (Stall_Cnt !== 32'd0 || Flush_Cnt !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_rst actual stall=%0d flush=%0d required 0 0", Stall_Cnt, Flush_Cnt);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_wrap();
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        step(); chk_if("wrap_tgt", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 10'h0);
        set_in(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        step(); chk_if("wrap_zero", 32'h0, mem(32'hFFFF_FFFC), 32'h0, 1'b1, 10'h0);
        step(); chk_if("wrap_next", 32'h4, mem(32'h0), 32'h4, 1'b1, CTRL);
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        ID_Ctrl_in = CTRL;
        test_reset();
        test_sequential();
        test_load_use();
        test_branch();
        test_branch_under_stall();
        test_inconsistent();
        test_watchdog();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
